// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: round-robin sharing of one registered bitwise logic unit
// among NREQ requesters, with a single valid/ready response register.
//
// state | meaning
// EMPTY | response register holds nothing (rsp_valid = 0)
// FULL  | response register holds a result awaiting rsp_ready
module logic_op_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_y,
    output logic                  rsp_err,
    output logic [15:0]           ops_done
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   winner;
    logic             found;
    logic             free;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] result;

    assign rsp_valid = (state == FULL);
    assign free      = (state == EMPTY) || rsp_ready;

    // Round-robin scan starting one past the last granted requester.
    always_comb begin
        logic [IDW-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_grant) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Reset gates the accept so a request in the reset cycle is dropped.
    assign accept = found && free && !rst;

    // One-hot ready toward the winner only when the output register is free.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign sel_a  = req_a[winner*WIDTH +: WIDTH];
    assign sel_b  = req_b[winner*WIDTH +: WIDTH];
    assign sel_op = req_op[winner*3 +: 3];

    // Shared gate datapath; illegal opcodes produce zero.
    always_comb begin
        result = '0;
        case (sel_op)
            3'd0:    result = sel_a & sel_b;
            3'd1:    result = sel_a | sel_b;
            3'd2:    result = ~sel_a;
            3'd3:    result = sel_a ^ sel_b;
            3'd4:    result = ~(sel_a ^ sel_b);
            3'd5:    result = ~(sel_a & sel_b);
            default: result = '0;
        endcase
    end

    // Control FSM, response register, grant pointer and accept counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            rsp_y      <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            ops_done   <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) state <= FULL;
                end
                FULL: begin
                    if (!accept && rsp_ready) state <= EMPTY;
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                rsp_y      <= result;
                rsp_id     <= winner;
                rsp_err    <= (sel_op > 3'd5);
                last_grant <= winner;
                if (ops_done != 16'hFFFF) begin
                    ops_done <= ops_done + 16'd1;
                end
            end
        end
    end

endmodule
